// File: rtl/fifo_arb_pkg.sv
// Shared types for the two-requester FIFO write arbiter.
// FSM state encoding and requester count.
package fifo_arb_pkg;

  localparam int NREQ = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARB,
    S_XFER,
    S_GAP
  } state_t;

endpackage

// File: rtl/fifo_arb_rr.sv
// Two-way round-robin picker, purely combinational.
// last_owner=1 means requester 1 was served last, so 0 wins a tie.
module fifo_arb_rr
  import fifo_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic            last_owner,
  output logic [NREQ-1:0] winner
);

  logic both;
  logic only0;
  logic only1;

  assign both  = req[0] & req[1];
  assign only0 = req[0] & ~req[1];
  assign only1 = req[1] & ~req[0];

  // Pick one-hot winner; a tie goes to whoever was not served last.
  always_comb begin
    winner = '0;
    unique case (1'b1)
      both:    winner = last_owner ? 2'b01 : 2'b10;
      only0:   winner = 2'b01;
      only1:   winner = 2'b10;
      default: winner = '0;
    endcase
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Burst arbiter feeding one FIFO write port from two requesters.
// Define FIFO_WR_ARB_FIXED_PRIO_EN to make requester 0 win every tie.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int DW    = 8,
  parameter int BURST = 16,
  parameter int GAP   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [DW-1:0]   din0,
  input  logic [DW-1:0]   din1,
  input  logic            wrfull,
  output logic [NREQ-1:0] grant,
  output logic [NREQ-1:0] pop,
  output logic            wrreq,
  output logic [DW-1:0]   wrdata,
  output logic            burst_done,
  output logic            burst_abort
);

  localparam int CW = $clog2(BURST + 1);
  localparam logic [CW-1:0] LAST =
    CW'(BURST - 1);
  localparam logic [3:0] GAP_LAST =
    4'((GAP > 0) ? GAP - 1 : 0);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [3:0]      gap_cnt;
  logic            last_owner;
  logic [NREQ-1:0] winner;
  logic            xfer;
  logic            own_req;
  logic            ends;

`ifdef FIFO_WR_ARB_FIXED_PRIO_EN
  assign last_owner = 1'b1;
`else
  // Remember who finished the most recent burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner <= 1'b1;
    end else if (ends) begin
      last_owner <= grant[1];
    end
  end
`endif

  fifo_arb_rr u_rr (
    .req        (req),
    .last_owner (last_owner),
    .winner     (winner)
  );

  assign xfer        = (state == S_XFER);
  assign own_req     = |(grant & req);
  assign burst_abort = xfer & ~own_req;
  assign pop         = xfer
                     ? (grant & req & {NREQ{~wrfull}})
                     : '0;
  assign wrreq       = |pop;
  assign burst_done  = wrreq & (cnt == LAST);
  assign ends        = burst_done | burst_abort;

  // Steer the granted requester's data; zero when nobody owns the port.
  always_comb begin
    wrdata = '0;
    unique case (1'b1)
      grant[0]: wrdata = din0;
      grant[1]: wrdata = din1;
      default:  wrdata = '0;
    endcase
  end

  // Burst FSM with registered grant, word and gap counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      grant   <= '0;
      cnt     <= '0;
      gap_cnt <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (|req) state <= S_ARB;
        end
        S_ARB: begin
          cnt <= '0;
          if (|req) begin
            grant <= winner;
            state <= S_XFER;
          end else begin
            state <= S_IDLE;
          end
        end
        S_XFER: begin
          if (wrreq) cnt <= cnt + 1'b1;
          if (ends) begin
            grant   <= '0;
            gap_cnt <= '0;
            state   <= (GAP == 0) ? S_IDLE : S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Random-stimulus bench for fifo_wr_arb with a burst-level model.
// Model tracks owner, words left and gap time, not the RTL states.
module tb_fifo_wr_arb;

  localparam int DW    = 8;
  localparam int BURST = 4;
  localparam int GAP   = 1;
  localparam int NCYC  = 3200;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req;
  logic [DW-1:0] din0;
  logic [DW-1:0] din1;
  logic          wrfull;
  logic [1:0]    grant;
  logic [1:0]    pop;
  logic          wrreq;
  logic [DW-1:0] wrdata;
  logic          burst_done;
  logic          burst_abort;

  fifo_wr_arb #(
    .DW    (DW),
    .BURST (BURST),
    .GAP   (GAP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .din0        (din0),
    .din1        (din1),
    .wrfull      (wrfull),
    .grant       (grant),
    .pop         (pop),
    .wrreq       (wrreq),
    .wrdata      (wrdata),
    .burst_done  (burst_done),
    .burst_abort (burst_abort)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // Model: owner=-1 means no burst in flight.
  int m_owner;
  int m_left;
  int m_gap;
  int m_last;
  bit m_arb;

  task automatic model_reset();
    m_owner = -1;
    m_left  = 0;
    m_gap   = 0;
    m_last  = 1;
    m_arb   = 0;
  endtask

  function automatic int pick(input logic [1:0] r, input int last);
    if (r == 2'b11) begin
`ifdef FIFO_WR_ARB_FIXED_PRIO_EN
      return 0;
`else
      return (last == 1) ? 0 : 1;
`endif
    end
    return r[0] ? 0 : 1;
  endfunction

  logic [1:0]    e_grant;
  logic [1:0]    e_pop;
  logic          e_done;
  logic          e_abort;
  logic [DW-1:0] e_data;
  int            cur_words;
  int            rst_hold;
  bit            forced_rst;

  initial begin
    rst_n = 1'b0;
    req = '0;
    din0 = '0;
    din1 = '0;
    wrfull = 1'b0;
    model_reset();
    cur_words = 0;
    rst_hold = 0;
    forced_rst = 0;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      din0 = DW'($urandom);
      din1 = DW'($urandom);
      if (c < 3) begin
        rst_n = 1'b0;
        req = 2'b11;
      end else if (c < 40) begin
        rst_n = 1'b1;
        req = 2'b01;
        wrfull = 1'b0;
      end else if (c < 100) begin
        req = 2'b11;
        wrfull = 1'b0;
        if (rst_hold > 0) begin
          rst_hold--;
          rst_n = (rst_hold == 0);
        end else if (!forced_rst && c > 60 &&
                     m_owner >= 0 && m_left == 2) begin
          forced_rst = 1;
          rst_n = 1'b0;
          rst_hold = 2;
        end
      end else begin
        if ($urandom_range(0, 7) == 0) req[0] = ~req[0];
        if ($urandom_range(0, 7) == 0) req[1] = ~req[1];
        wrfull = ($urandom_range(0, 3) == 0);
        if (rst_hold > 0) begin
          rst_hold--;
          rst_n = (rst_hold == 0);
        end else if (m_owner >= 0 &&
                     $urandom_range(0, 299) == 0) begin
          rst_n = 1'b0;
          rst_hold = 2;
        end
      end
      #1;
      if (!rst_n) begin
        model_reset();
        cur_words = 0;
      end
      e_grant = '0;
      e_pop   = '0;
      e_done  = 1'b0;
      e_abort = 1'b0;
      e_data  = '0;
      if (m_owner >= 0) begin
        e_grant = 2'(1 << m_owner);
        e_data  = (m_owner == 1) ? din1 : din0;
        if (!req[m_owner]) e_abort = 1'b1;
        else if (!wrfull) e_pop = e_grant;
        e_done = (e_pop != 0) && (m_left == 1);
      end
      check("grant", 32'(grant), 32'(e_grant));
      check("pop", 32'(pop), 32'(e_pop));
      check("wrreq", 32'(wrreq), 32'(e_pop != 0));
      check("wrdata", 32'(wrdata), 32'(e_data));
      check("burst_done", 32'(burst_done), 32'(e_done));
      check("burst_abort", 32'(burst_abort), 32'(e_abort));
      check("wrreq_while_full", 32'(wrreq & wrfull), 32'd0);
      check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
      if (burst_done)
        check("burst_len", 32'(cur_words + 1), 32'(BURST));
      if (burst_done || burst_abort) cur_words = 0;
      else if (wrreq) cur_words++;
      @(posedge clk);
      if (rst_n) begin
        if (m_arb) begin
          m_arb = 0;
          if (req != 0) begin
            m_owner = pick(req, m_last);
            m_left  = BURST;
          end
        end else if (m_owner >= 0) begin
          if (e_abort || e_done) begin
            m_last  = m_owner;
            m_owner = -1;
            m_gap   = GAP;
          end else if (e_pop != 0) begin
            m_left--;
          end
        end else if (m_gap > 0) begin
          m_gap--;
        end else if (req != 0) begin
          m_arb = 1;
        end
      end
    end
    check("forced_mid_burst_reset", 32'(forced_rst), 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
